// File: rtl/vis_axis_bytes.sv
// Visibility-to-byte serialiser: each accepted {re, im} pair leaves as 2*ACCUM/8 big-endian bytes, real first.
// Optional per-frame header (A5 5A seq_hi seq_lo) is built when VIS_HEADER_EN is defined.
module vis_axis_bytes #(
  parameter int unsigned ACCUM = 32,
  parameter int unsigned SBITS = 16
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             s_tvalid_i,
  output logic             s_tready_o,
  input  logic             s_tlast_i,
  input  logic [ACCUM-1:0] s_revis_i,
  input  logic [ACCUM-1:0] s_imvis_i,
  output logic             m_tvalid_o,
  input  logic             m_tready_i,
  output logic             m_tlast_o,
  output logic [7:0]       m_tdata_o,
  output logic             busy_o,
  output logic [SBITS-1:0] seq_o
);

  localparam int unsigned NB = (2 * ACCUM) / 8;
  localparam int unsigned IW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(NB - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1
`ifdef VIS_HEADER_EN
    , ST_HEAD = 2'd2
`endif
  } state_e;

  state_e           state_q;
  logic [ACCUM-1:0] re_q;
  logic [ACCUM-1:0] im_q;
  logic             last_q;
  logic [IW-1:0]    idx_q;
  logic [SBITS-1:0] seq_q;
  logic             mvalid_q;
  logic             mlast_q;
  logic [7:0]       mdata_q;
`ifdef VIS_HEADER_EN
  logic [1:0]       hidx_q;
  logic             sof_q;
`endif

  logic          xfer;
  logic          last_data;
  logic          accept;
  logic [IW-1:0] idx_inc;

  // Byte k of the big-endian {re, im} concatenation.
  function automatic logic [7:0] pick(input logic [ACCUM-1:0] re,
                                      input logic [ACCUM-1:0] im,
                                      input logic [IW-1:0]    k);
    logic [2*ACCUM-1:0] sh;
    sh = {re, im} >> (8 * (NB - 1 - 32'(k)));
    return sh[7:0];
  endfunction

`ifdef VIS_HEADER_EN
  function automatic logic [7:0] hdr_byte(input logic [1:0] h, input logic [SBITS-1:0] s);
    logic [7:0] b;
    case (h)
      2'd0:    b = 8'hA5;
      2'd1:    b = 8'h5A;
      2'd2:    b = s[15:8];
      default: b = s[7:0];
    endcase
    return b;
  endfunction
`endif

  assign xfer      = mvalid_q && m_tready_i;
  assign last_data = (state_q == ST_DATA) && (idx_q == IDX_LAST);
  assign idx_inc   = idx_q + 1'b1;

  // Ready while idle, or on the cycle the final byte drains, for zero-bubble streaming.
  assign s_tready_o = aresetn && ((state_q == ST_IDLE) || (last_data && m_tready_i));
  assign accept     = s_tvalid_i && s_tready_o;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q  <= ST_IDLE;
      re_q     <= '0;
      im_q     <= '0;
      last_q   <= 1'b0;
      idx_q    <= '0;
      seq_q    <= '0;
      mvalid_q <= 1'b0;
      mlast_q  <= 1'b0;
      mdata_q  <= 8'h00;
`ifdef VIS_HEADER_EN
      hidx_q   <= 2'd0;
      sof_q    <= 1'b1;
`endif
    end else begin
      if (xfer && mlast_q) begin
        seq_q <= SBITS'(seq_q + 1'b1);
      end

      if (accept) begin
        re_q     <= s_revis_i;
        im_q     <= s_imvis_i;
        last_q   <= s_tlast_i;
        idx_q    <= '0;
        mvalid_q <= 1'b1;
        mlast_q  <= 1'b0;
`ifdef VIS_HEADER_EN
        // A word carrying last makes the next accepted word open a new frame.
        sof_q    <= s_tlast_i;
        hidx_q   <= 2'd0;
        if (sof_q) begin
          state_q <= ST_HEAD;
          mdata_q <= 8'hA5;
        end else begin
          state_q <= ST_DATA;
          mdata_q <= pick(s_revis_i, s_imvis_i, IW'(0));
        end
`else
        state_q  <= ST_DATA;
        mdata_q  <= pick(s_revis_i, s_imvis_i, IW'(0));
`endif
      end else if (xfer) begin
        case (state_q)
`ifdef VIS_HEADER_EN
          ST_HEAD: begin
            if (hidx_q == 2'd3) begin
              state_q <= ST_DATA;
              idx_q   <= '0;
              mdata_q <= pick(re_q, im_q, IW'(0));
              mlast_q <= 1'b0;
            end else begin
              hidx_q  <= hidx_q + 2'd1;
              mdata_q <= hdr_byte(hidx_q + 2'd1, seq_q);
            end
          end
`endif
          ST_DATA: begin
            if (idx_q == IDX_LAST) begin
              state_q  <= ST_IDLE;
              mvalid_q <= 1'b0;
              mlast_q  <= 1'b0;
            end else begin
              idx_q   <= idx_inc;
              mdata_q <= pick(re_q, im_q, idx_inc);
              mlast_q <= last_q && (idx_inc == IDX_LAST);
            end
          end
          default: begin
            state_q  <= ST_IDLE;
            mvalid_q <= 1'b0;
            mlast_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign m_tvalid_o = mvalid_q;
  assign m_tlast_o  = mlast_q;
  assign m_tdata_o  = mdata_q;
  assign busy_o     = (state_q != ST_IDLE);
  assign seq_o      = seq_q;

endmodule

// File: tb/tb_vis_axis_bytes.sv
// Self-checking bench for vis_axis_bytes: directed table, multi-cycle corner sequences and random traffic
// checked against a byte-queue reference model.
module tb_vis_axis_bytes;

  localparam int unsigned ACCUM = 32;
`ifdef VIS_HEADER_EN
  localparam int HB = 4;
`else
  localparam int HB = 0;
`endif

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        s_tvalid_i;
  logic        s_tready_o;
  logic        s_tlast_i;
  logic [31:0] s_revis_i;
  logic [31:0] s_imvis_i;
  logic        m_tvalid_o;
  logic        m_tready_i;
  logic        m_tlast_o;
  logic [7:0]  m_tdata_o;
  logic        busy_o;
  logic [15:0] seq_o;

  vis_axis_bytes #(.ACCUM(ACCUM), .SBITS(16)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_tvalid_i(s_tvalid_i), .s_tready_o(s_tready_o), .s_tlast_i(s_tlast_i),
    .s_revis_i(s_revis_i), .s_imvis_i(s_imvis_i),
    .m_tvalid_o(m_tvalid_o), .m_tready_i(m_tready_i), .m_tlast_o(m_tlast_o),
    .m_tdata_o(m_tdata_o), .busy_o(busy_o), .seq_o(seq_o)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } byte_t;

  typedef struct {
    logic [31:0] re;
    logic [31:0] im;
    logic        last;
    logic [63:0] bytes;
    logic [15:0] seq;
  } vec_t;

  byte_t       mq[$];
  byte_t       cap[$];
  int          checks = 0;
  int          failures = 0;
  logic [15:0] mseq = 16'h0;
  bit          msof = 1'b1;
  bit          prev_stall = 1'b0;
  logic [7:0]  prev_data;
  logic        prev_last;
  bit          last_acc;
  bit          last_xfer;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endfunction

  // Reference: queue every byte the word must produce, header first when a frame opens.
  task automatic push_word(input logic [31:0] re, input logic [31:0] im, input logic l);
    logic [63:0] w;
    w = {re, im};
    if (HB != 0 && msof) begin
      mq.push_back({8'hA5, 1'b0});
      mq.push_back({8'h5A, 1'b0});
      mq.push_back({mseq[15:8], 1'b0});
      mq.push_back({mseq[7:0], 1'b0});
    end
    for (int k = 0; k < 8; k++) mq.push_back({w[63-8*k -: 8], l && (k == 7)});
    msof = l;
  endtask

  // One clock: drive at negedge, check settled outputs, account for the coming posedge.
  task automatic cycle(input logic tv, input logic tl, input logic [31:0] re,
                       input logic [31:0] im, input logic mr);
    bit    exp_rdy;
    byte_t e;
    s_tvalid_i = tv;
    s_tlast_i  = tl;
    s_revis_i  = re;
    s_imvis_i  = im;
    m_tready_i = mr;
    #1;
    exp_rdy = (mq.size() == 0) || (mq.size() == 1 && mr);
    chk("s_tready", s_tready_o, exp_rdy);
    chk("m_tvalid", m_tvalid_o, mq.size() != 0);
    chk("busy", busy_o, mq.size() != 0);
    chk("seq", seq_o, mseq);
    if (prev_stall) begin
      chk("hold_data", m_tdata_o, prev_data);
      chk("hold_last", m_tlast_o, prev_last);
    end
    last_xfer = m_tvalid_o && mr;
    if (last_xfer) begin
      if (mq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_byte actual=0x%0h required=none", m_tdata_o);
      end else begin
        e = mq.pop_front();
        chk("byte_data", m_tdata_o, e.d);
        chk("byte_last", m_tlast_o, e.l);
        if (e.l) mseq++;
      end
      cap.push_back({m_tdata_o, m_tlast_o});
    end
    prev_stall = m_tvalid_o && !mr;
    prev_data  = m_tdata_o;
    prev_last  = m_tlast_o;
    last_acc   = tv && s_tready_o;
    if (last_acc) push_word(re, im, tl);
    @(negedge aclk);
  endtask

  task automatic do_reset(input int n);
    aresetn    = 1'b0;
    s_tvalid_i = 1'b0;
    s_tlast_i  = 1'b0;
    s_revis_i  = '0;
    s_imvis_i  = '0;
    m_tready_i = 1'b0;
    #1;
    chk("rst_s_tready", s_tready_o, 0);
    repeat (n) @(negedge aclk);
    chk("rst_m_tvalid", m_tvalid_o, 0);
    chk("rst_m_tlast", m_tlast_o, 0);
    chk("rst_m_tdata", m_tdata_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_seq", seq_o, 0);
    chk("rst_s_tready_low", s_tready_o, 0);
    mq.delete();
    mseq       = 16'h0;
    msof       = 1'b1;
    prev_stall = 1'b0;
    aresetn    = 1'b1;
  endtask

  task automatic drain(output int n);
    n = 0;
    while (mq.size() != 0 && n < 200) begin
      cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      n++;
    end
    if (mq.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d required=0", mq.size());
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[4];
    logic [63:0] bv;
    logic [7:0]  expb[$];
    bit          start;
    logic [15:0] hseq;
    int          n, k, first_x, last_x;
    logic [31:0] bre[8];
    logic [31:0] bim[8];

    tbl[0] = '{32'h11223344, 32'h55667788, 1'b1, 64'h1122334455667788, 16'd1};
    tbl[1] = '{32'hDEADBEEF, 32'h01234567, 1'b0, 64'hDEADBEEF01234567, 16'd1};
    tbl[2] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 64'hFFFFFFFF00000000, 16'd2};
    tbl[3] = '{32'h80000001, 32'h7F00FF80, 1'b1, 64'h800000017F00FF80, 16'd3};

    do_reset(2);

    // Directed table: one word each, downstream always ready.
    for (int i = 0; i < 4; i++) begin
      cap.delete();
      expb.delete();
      start = (i == 0) || tbl[i-1].last;
      hseq  = (i == 0) ? 16'd0 : tbl[i-1].seq;
      bv    = tbl[i].bytes;
      if (HB != 0 && start) begin
        expb.push_back(8'hA5);
        expb.push_back(8'h5A);
        expb.push_back(hseq[15:8]);
        expb.push_back(hseq[7:0]);
      end
      for (int b = 0; b < 8; b++) expb.push_back(bv[63-8*b -: 8]);
      cycle(1'b1, tbl[i].last, tbl[i].re, tbl[i].im, 1'b1);
      drain(n);
      chk("tbl_cycles", n, expb.size());
      chk("tbl_count", cap.size(), expb.size());
      for (int b = 0; b < expb.size() && b < cap.size(); b++) begin
        chk("tbl_byte", cap[b].d, expb[b]);
        chk("tbl_last", cap[b].l, tbl[i].last && (b == expb.size() - 1));
      end
      chk("tbl_seq", seq_o, tbl[i].seq);
    end

    // Downstream ready toggling 1/0: every byte held through its stall.
    cap.delete();
    cycle(1'b1, 1'b1, 32'h11223344, 32'h55667788, 1'b1);
    n = 0;
    while (mq.size() != 0 && n < 100) begin
      cycle(1'b0, 1'b0, 32'h0, 32'h0, (n % 2) == 0);
      n++;
    end
    chk("stall_cycles", n, 2 * (8 + HB) - 1);
    chk("stall_count", cap.size(), 8 + HB);
    chk("stall_first", cap[HB].d, 8'h11);
    chk("stall_final", cap[HB+7].d, 8'h88);
    chk("stall_final_last", cap[HB+7].l, 1);
    chk("stall_seq", seq_o, 16'd4);
`ifdef VIS_HEADER_EN
    chk("stall_hdr_lo", cap[3].d, 8'h03);
`endif

    // Eight back-to-back words with s_tvalid held high.
    for (int i = 0; i < 8; i++) begin
      bre[i] = {8'(i), 24'hA0B0C0};
      bim[i] = 32'h5500_0000 + 32'(i);
    end
    cap.delete();
    k = 0;
    first_x = -1;
    last_x = -1;
    for (int c = 0; c < 200 && (k < 8 || mq.size() != 0); c++) begin
      if (k < 8) cycle(1'b1, k == 7, bre[k], bim[k], 1'b1);
      else cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      if (last_xfer) begin
        if (first_x < 0) first_x = c;
        last_x = c;
      end
      if (last_acc) begin
        chk("b2b_accept_cycle", c, k * 8 + ((k > 0) ? HB : 0));
        k++;
      end
    end
    chk("b2b_words", k, 8);
    chk("b2b_bytes", cap.size(), 64 + HB);
    chk("b2b_span", last_x - first_x + 1, 64 + HB);

    // Reset while a word is part-way out.
    cycle(1'b1, 1'b0, 32'hA1A2A3A4, 32'hB1B2B3B4, 1'b1);
    repeat (3) cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    do_reset(1);
    cap.delete();
    cycle(1'b1, 1'b1, 32'hC0C1C2C3, 32'hD0D1D2D3, 1'b1);
    drain(n);
    chk("post_rst_count", cap.size(), 8 + HB);
    chk("post_rst_first", cap[0].d, (HB != 0) ? 8'hA5 : 8'hC0);
    chk("post_rst_byte0", cap[HB].d, 8'hC0);
    chk("post_rst_seq", seq_o, 16'd1);
`ifdef VIS_HEADER_EN
    chk("post_rst_hdr_hi", cap[2].d, 8'h00);
    chk("post_rst_hdr_lo", cap[3].d, 8'h00);
`endif

    // Frame counter wrap from 0xFFFF.
    force dut.seq_q = 16'hFFFF;
    @(posedge aclk);
    #1;
    release dut.seq_q;
    @(negedge aclk);
    mseq = 16'hFFFF;
    chk("wrap_preload", seq_o, 16'hFFFF);
    cap.delete();
    cycle(1'b1, 1'b1, 32'h0BADF00D, 32'hCAFEBABE, 1'b1);
    drain(n);
    chk("wrap_seq", seq_o, 16'h0000);
    chk("wrap_count", cap.size(), 8 + HB);
`ifdef VIS_HEADER_EN
    chk("wrap_hdr_hi", cap[2].d, 8'hFF);
    chk("wrap_hdr_lo", cap[3].d, 8'hFF);
`endif

    // Random traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      if (($urandom % 400) == 0) do_reset(1);
      else cycle(($urandom % 2) == 0, ($urandom % 3) == 0, $urandom, $urandom, ($urandom % 4) != 0);
    end
    drain(n);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vis_axis_bytes.md
# vis_axis_bytes

Byte-serialiser between the correlator's visibility read-out bus and the USB bulk IN endpoint's 8-bit AXI-stream input. Each accepted visibility (real, imaginary pair of ACCUM-bit words) is emitted as 2*ACCUM/8 bytes, big-endian, real first. The correlator's last flag is carried to `m_tlast_o` on the final byte of that visibility. The block runs on the single AXI clock domain (`aclk`).

## Interface
- `ACCUM`, 32, visibility component width in bits; multiple of 8, range 8..32
- `SBITS`, 16, frame sequence counter width (header build only; fixed at 16)
- `aclk`  in  1  system clock; all logic on rising edge
- `aresetn`  in  1  reset; **synchronous, active-low**
- `s_tvalid_i`  in  1  visibility valid (correlator `bus_valid`)
- `s_tready_o`  out  1  visibility accepted this cycle when high with `s_tvalid_i`
- `s_tlast_i`  in  1  final visibility of frame
- `s_revis_i`  in  ACCUM  real component
- `s_imvis_i`  in  ACCUM  imaginary component
- `m_tvalid_o`  out  1  byte valid
- `m_tready_i`  in  1  downstream ready
- `m_tlast_o`  out  1  final byte of frame
- `m_tdata_o`  out  8  byte
- `busy_o`  out  1  state != IDLE
- `seq_o`  out  16  completed-frame count

## Operation
- Holding register: {re, im, last}, loaded on s_tvalid_i && s_tready_o. Byte index `idx` counts 0..NB-1, NB = 2*ACCUM/8.
- Byte k: k < NB/2 -> re[ACCUM-1-8k -: 8]; else im[ACCUM-1-8(k-NB/2) -: 8].
- States:
  - IDLE -> DATA on accept (or HEAD if header compiled in and at start of frame).
  - HEAD: 4 header bytes; -> DATA after the 4th byte transfers.
  - DATA: advance idx on each m_tvalid_o && m_tready_i.
- Last byte of DATA transfers:
  - if a new word is accepted in the same cycle -> DATA (or HEAD if the previous word had last set and header is enabled), idx = 0;
  - else -> IDLE.
- `s_tready_o` = aresetn && (state==IDLE || (state==DATA && idx==NB-1 && m_tready_i)). Combinational path from m_tready_i to s_tready_o is intentional and gives zero-bubble streaming.
- `m_tlast_o` = held last && idx==NB-1 && state==DATA.
- `seq_o` increments (mod 2^16) when a byte with m_tlast_o transfers.
- AXI rules: m_tdata_o and m_tlast_o stay stable while m_tvalid_o && !m_tready_i. m_tvalid_o never drops without a transfer.

## Timing
- Reset values: m_tvalid_o 0, m_tlast_o 0, m_tdata_o 8'h00, s_tready_o 0 (while aresetn low), busy_o 0, seq_o 0, state IDLE, idx 0.
- Latency: word accepted at edge N -> first byte valid after edge N (visible cycle N+1).
- Throughput: one byte per cycle under continuous m_tready_i; back-to-back visibilities produce no idle cycle.
- Reset asserted mid-word or mid-header: partial word discarded, no m_tlast_o emitted, seq_o cleared. The first accept after reset starts a new frame.
- s_tlast_i is sampled only on accept. s_tvalid_i is ignored while s_tready_o is low.
- seq_o wraps 0xFFFF -> 0x0000.

## Configuration
- `VIS_HEADER_EN` defined:
  - before the first visibility of each frame (first after reset, or after a word with last set), emit 4 bytes: 8'hA5, 8'h5A, seq_o[15:8], seq_o[7:0];
  - header bytes never carry m_tlast_o;
  - frame length = 4 + NB*words.
- `VIS_HEADER_EN` undefined: HEAD state and header logic absent; output is pure visibility bytes.

## Test plan
- ACCUM=32, no header, re=32'h11223344, im=32'h55667788, last=1, m_tready=1 -> bytes 11 22 33 44 55 66 77 88 on 8 consecutive cycles, m_tlast only on 88, seq_o=1.
- Same word, m_tready toggled 1/0 every cycle -> identical byte sequence; data and last held stable during stalls; 15 cycles total.
- 8 back-to-back words, s_tvalid held high, m_tready=1 -> 64 bytes in 64 consecutive cycles; s_tready high exactly on cycles 0, 8, ... 56.
- VIS_HEADER_EN, two 2-word frames -> A5 5A 00 00 + 16 bytes (tlast), then A5 5A 00 01 + 16 bytes (tlast); seq_o=2.
- aresetn low for 1 cycle at byte 3 of a word -> m_tvalid 0 the next cycle, seq_o=0; a following word emits from byte 0 (header 00 00 if enabled).
- Force seq_o to 16'hFFFF (fill 65535 one-word frames), send one frame -> seq_o=0; header build shows FF FF in that frame's header.
